uart_reg_responder: RTL and testbench

UART_REG_RESPONDER -- requirements
Module: uart_reg_responder

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_timeout_cnt.sv | 33 +++
 rtl/uart_reg_responder.sv | 130 +++++++++++++
 tb/tb_uart_reg_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared opcodes, response codes and FSM encoding for the UART
// register responder and its host-side test model.
package uart_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    RESP
  } state_e;

  function automatic logic is_op(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timer: cleared by load, counts while enabled,
// saturates at TIMEOUT and flags expiry there.
module uart_timeout_cnt #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIM = W'(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (en_i && cnt_q != LIM)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == LIM);

endmodule

// File: rtl/uart_reg_responder.sv
// Byte-framed register file behind a UART FIFO pair:
// write 0x57,addr,data / read 0x52,addr, one response byte each.
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int NREG    = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [7:0]        w_data,
  output logic              wr_uart,
  output logic [8*NREG-1:0] regs,
  output logic              reg_we,
  output logic [7:0]        reg_addr
);

  localparam int AW = $clog2(NREG);
  localparam logic [8:0] NREG_L = 9'(NREG);

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rsp_q, rsp_d;
  logic [7:0] last_q, last_d;
  logic [7:0] regs_q [NREG];

  logic take, waiting, legal, is_wr, expire;
  logic [AW-1:0] idx;

  assign waiting = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign take    = rst && !rx_empty && (waiting || state_q == IDLE);
  assign is_wr   = (op_q == OP_WR);
  assign legal   = ({1'b0, addr_q} < NREG_L);
  assign idx     = addr_q[AW-1:0];

  assign rd_uart  = take;
  assign wr_uart  = rst && (state_q == RESP) && !tx_full;
  assign w_data   = rsp_q;
  assign reg_we   = (state_q == EXEC) && is_wr && legal;
  assign reg_addr = reg_we ? addr_q : last_q;

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign regs[8*i +: 8] = regs_q[i];
  end

  // Timer only runs while a frame is partially received.
  uart_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load_i   (take || !waiting),
    .en_i     (waiting),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: if (take) begin
        op_d    = r_data;
        state_d = is_op(r_data) ? GET_ADDR : EXEC;
      end
      GET_ADDR: if (take) begin
        addr_d  = r_data;
        state_d = is_wr ? GET_DATA : EXEC;
      end else if (expire) begin
        state_d = IDLE;
      end
      GET_DATA: if (take) begin
        data_d  = r_data;
        state_d = EXEC;
      end else if (expire) begin
        state_d = IDLE;
      end
      EXEC: begin
        state_d = RESP;
        if (!is_op(op_q) || !legal) begin
          rsp_d = RSP_ERR;
        end else if (is_wr) begin
          rsp_d  = RSP_OK;
          last_d = addr_q;
        end else begin
          rsp_d = regs_q[idx];
        end
      end
      RESP: if (wr_uart) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench: a queue models the RX FIFO, expected
// responses and register writes are queued as frames are sent.
module tb_uart_reg_responder;
  import uart_pkg::*;

  localparam int NREG = 16;
  localparam int TMO  = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx_empty = 1'b1;
  logic [7:0]        r_data = 8'h00;
  logic              tx_full = 1'b0;
  logic              rd_uart, wr_uart, reg_we;
  logic [7:0]        w_data, reg_addr;
  logic [8*NREG-1:0] regs;

  always #5 clk = ~clk;

  uart_reg_responder #(
    .NREG    (NREG),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .regs     (regs),
    .reg_we   (reg_we),
    .reg_addr (reg_addr)
  );

  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] we_q [$];
  logic [7:0] mdl [NREG];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_pop = 0;
  int n_pop = 0, n_wr = 0, n_we = 0;
  int p0, w0, e0;
  bit skip_lat = 1'b0;

  task automatic chk(string tag, logic [127:0] got,
                     logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mdl_flat();
    logic [127:0] f;
    for (int i = 0; i < NREG; i++) f[8*i +: 8] = mdl[i];
    return f;
  endfunction

  task automatic sync_rx();
    rx_empty = (rx_q.size() == 0);
    r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    sync_rx();
  endtask

  task automatic tick();
    bit pop;
    pop = 1'b0;
    @(negedge clk);
    if (rd_uart) begin
      pop = 1'b1;
      n_pop++;
      last_pop = cyc;
    end
    if (wr_uart) begin
      n_wr++;
      if (tx_full) chk("wr_while_full", tx_full, 1'b0);
      if (exp_q.size() == 0)
        chk("rsp_pending", exp_q.size(), 1);
      else
        chk("rsp", w_data, exp_q.pop_front());
      if (!skip_lat) chk("latency", cyc - last_pop, 2);
      skip_lat = 1'b0;
    end
    if (reg_we) begin
      n_we++;
      if (we_q.size() == 0)
        chk("we_pending", we_q.size(), 1);
      else
        chk("we_addr", reg_addr, we_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
    sync_rx();
  endtask

  task automatic fr_wr(input logic [7:0] a, input logic [7:0] d);
    send(OP_WR);
    send(a);
    send(d);
    if (a < NREG) begin
      mdl[a] = d;
      exp_q.push_back(RSP_OK);
      we_q.push_back(a);
    end else begin
      exp_q.push_back(RSP_ERR);
    end
  endtask

  task automatic fr_rd(input logic [7:0] a);
    send(OP_RD);
    send(a);
    exp_q.push_back((a < NREG) ? mdl[a] : RSP_ERR);
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && rx_q.size() == 0) break;
      tick();
    end
    chk("drained", exp_q.size() + rx_q.size(), 0);
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;

    rst = 1'b0;
    repeat (3) tick();
    chk("rst_rd_uart", rd_uart, 1'b0);
    chk("rst_wr_uart", wr_uart, 1'b0);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_w_data", w_data, 8'h00);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_regs", regs, 128'h0);
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_no_pop", n_pop, 0);

    fr_wr(8'h03, 8'hA5);
    fr_rd(8'h03);
    drain();
    chk("we_count", n_we, 1);
    chk("reg3", regs[31:24], 8'hA5);

    e0 = n_we;
    fr_rd(8'h10);
    fr_wr(8'h20, 8'h11);
    drain();
    chk("bad_addr_no_we", n_we - e0, 0);
    chk("regs_bad_addr", regs, mdl_flat());

    send(8'h33);
    exp_q.push_back(RSP_ERR);
    fr_rd(8'h00);
    drain();

    fr_wr(8'h0F, 8'hFF);
    fr_wr(8'h00, 8'h5A);
    fr_rd(8'h0F);
    fr_rd(8'h00);
    fr_wr(8'h07, 8'h81);
    fr_rd(8'h07);
    drain();
    chk("regs_mix", regs, mdl_flat());

    tx_full  = 1'b1;
    skip_lat = 1'b1;
    p0 = n_pop;
    w0 = n_wr;
    fr_wr(8'h05, 8'h3C);
    fr_rd(8'h05);
    repeat (50) tick();
    chk("hold_pops", n_pop - p0, 3);
    chk("hold_wr", n_wr - w0, 0);
    tx_full = 1'b0;
    tick();
    chk("release_wr", n_wr - w0, 1);
    drain();

    e0 = n_we;
    w0 = n_wr;
    send(OP_WR);
    send(8'h01);
    repeat (TMO + 5) tick();
    fr_rd(8'h01);
    drain();
    chk("tmo_no_we", n_we - e0, 0);
    chk("tmo_one_rsp", n_wr - w0, 1);

    w0 = n_wr;
    send(OP_WR);
    send(8'h02);
    repeat (4) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("abort_regs", regs, 128'h0);
    chk("abort_w_data", w_data, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
    repeat (3) tick();
    chk("abort_no_rsp", n_wr - w0, 0);
    for (int a = 0; a < NREG; a++) fr_rd(8'(a));
    drain();
    fr_wr(8'h09, 8'hC3);
    fr_rd(8'h09);
    drain();
    chk("regs_after_rst", regs, mdl_flat());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
